pulse_event_arbiter: RTL and testbench

Collects rising-edge events from N synchronous level inputs (buttons or single-pulser style strobes), queues one pending event per channel, and issues them one at a time to a shared downstream consumer over a valid/ready handshake. Grants are round-robin, with a programmable idle gap between issued events. It sits between the per-button input conditioning and the single command consumer, so simultaneous presses are never lost or merged across channels.

---
 rtl/pulse_event_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pulse_event_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter
// Turns rising edges on N synchronous level inputs into queued events, one
// pending slot per channel, and hands them one at a time to a single
// downstream consumer over valid/ready. Channels are served round-robin
// starting after the last channel that actually transferred, and a fixed
// number of idle cycles is inserted after every accepted event.
// Everything visible at the ports comes straight from flops.

module pulse_event_arbiter #(
    parameter int N   = 4,
    parameter int GAP = 2,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_id,
    output logic [N-1:0] pending,
    output logic [N-1:0] overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   in_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   xfer_vec;
    logic [N-1:0]   pending_nxt;
    logic [N-1:0]   overrun_nxt;
    logic           xfer;

    logic [W-1:0]   last;
    logic [W-1:0]   last_nxt;
    logic [W-1:0]   sel;
    logic           sel_found;
    int             sel_idx;
    logic [W-1:0]   sel_cand;

    logic           out_valid_nxt;
    logic [W-1:0]   out_id_nxt;
    logic [3:0]     gap_cnt;
    logic [3:0]     gap_nxt;

    assign rise = in & ~in_q;
    assign xfer = out_valid & out_ready;

    // Previous-cycle copy of the inputs; clearing it on reset means an input
    // already held high when reset releases is seen as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= '0;
        end else begin
            in_q <= in;
        end
    end

    // One-hot of the channel whose event the consumer takes this cycle.
    always_comb begin
        xfer_vec = '0;
        for (int i = 0; i < N; i++) begin
            xfer_vec[i] = xfer && (out_id == W'(i));
        end
    end

    // A new rise wins over a same-cycle transfer, so that edge is kept as a
    // new event; a rise onto an occupied, non-transferring slot is lost and
    // flagged sticky.
    always_comb begin
        pending_nxt = (pending & ~xfer_vec) | rise;
        overrun_nxt = overrun | (rise & pending & ~xfer_vec);
    end

    // Pending and overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    // Round-robin pick: scan from the channel after the last one served,
    // wrapping, and take the first pending channel. The last offset (k == N)
    // revisits the last-served channel so it can still win when alone.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        sel_idx   = 0;
        sel_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            sel_idx  = (int'(last) + k) % N;
            sel_cand = sel_idx[W-1:0];
            if (!sel_found && pending[sel_cand]) begin
                sel       = sel_cand;
                sel_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic. The presented id is captured
    // once on leaving IDLE and held while the consumer stalls; the pointer
    // only advances when an event is really accepted.
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        out_id_nxt    = out_id;
        gap_nxt       = gap_cnt;
        last_nxt      = last;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    out_id_nxt    = sel;
                    out_valid_nxt = 1'b1;
                    state_nxt     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    last_nxt      = out_id;
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                out_valid_nxt = 1'b0;
                gap_nxt       = 4'd0;
            end
        endcase
    end

    // State register plus the registered handshake outputs, pointer and
    // idle-gap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_id    <= '0;
            gap_cnt   <= 4'd0;
            last      <= W'(N - 1);
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            out_id    <= out_id_nxt;
            gap_cnt   <= gap_nxt;
            last      <= last_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter (N=4, GAP=2). Outputs are observed
// on the falling edge, inputs are changed right after observing, so every
// rising edge sees stable stimulus. Cycle c counts falling edges after the
// first stimulus is applied (c=0).

module tb_pulse_event_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int W   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_id;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_event_arbiter #(.N(N), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_id    (out_id),
        .pending   (pending),
        .overrun   (overrun)
    );

    // Hold reset for one cycle with inputs low; returns on the falling edge
    // where reset is released.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        in = '0;
        out_ready = rdy;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in = '0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_id got=%0d want=0", out_id); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL reset_pending got=%b want=0000", pending); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL reset_overrun got=%b want=0000", overrun); end
    endtask

    task automatic test_single_press();
        int pulses;
        pulses = 0;
        do_reset(1'b1);
        in = 4'b0100;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
            if (c == 1) begin
                total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL single_pending_set got=%b want=0100", pending); end
                total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_early got=%b want=0", out_valid); end
            end
            if (c == 2) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", out_valid); end
                total++; if (out_id !== 2'd2) begin bad++; $display("[TB] FAIL single_id got=%0d want=2", out_id); end
            end
            if (c == 3) begin
                total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL single_pending_clear got=%b want=0000", pending); end
            end
            if (c == 5) in = 4'b0000;
        end
        total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL single_pulse_count got=%0d want=1", pulses); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL single_overrun got=%b want=0000", overrun); end
    endtask

    task automatic test_simultaneous();
        int n;
        logic [W-1:0] ids [3];
        int at [3];
        n = 0;
        for (int i = 0; i < 3; i++) begin ids[i] = '1; at[i] = 0; end
        do_reset(1'b1);
        in = 4'b1011;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++; if (pending !== 4'b1011) begin bad++; $display("[TB] FAIL simul_pending got=%b want=1011", pending); end
            end
            if (out_valid === 1'b1) begin
                if (n < 3) begin ids[n] = out_id; at[n] = c; end
                n++;
            end
        end
        in = 4'b0000;
        total++; if (n !== 3) begin bad++; $display("[TB] FAIL simul_count got=%0d want=3", n); end
        total++; if (ids[0] !== 2'd0) begin bad++; $display("[TB] FAIL simul_id0 got=%0d want=0", ids[0]); end
        total++; if (ids[1] !== 2'd1) begin bad++; $display("[TB] FAIL simul_id1 got=%0d want=1", ids[1]); end
        total++; if (ids[2] !== 2'd3) begin bad++; $display("[TB] FAIL simul_id2 got=%0d want=3", ids[2]); end
        total++; if (at[0] !== 2) begin bad++; $display("[TB] FAIL simul_first_cycle got=%0d want=2", at[0]); end
        total++; if (at[1] - at[0] !== 4) begin bad++; $display("[TB] FAIL simul_spacing01 got=%0d want=4", at[1] - at[0]); end
        total++; if (at[2] - at[1] !== 4) begin bad++; $display("[TB] FAIL simul_spacing12 got=%0d want=4", at[2] - at[1]); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL simul_drained got=%b want=0000", pending); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [W-1:0] ids [3];
        n = 0;
        for (int i = 0; i < 3; i++) ids[i] = '1;
        do_reset(1'b1);
        in = 4'b0010;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (n < 3) ids[n] = out_id;
                n++;
            end
            if (c == 2) in = 4'b1011;
            if (c == 3) begin
                total++; if (pending !== 4'b1001) begin bad++; $display("[TB] FAIL rr_pending got=%b want=1001", pending); end
            end
        end
        in = 4'b0000;
        total++; if (n !== 3) begin bad++; $display("[TB] FAIL rr_count got=%0d want=3", n); end
        total++; if (ids[0] !== 2'd1) begin bad++; $display("[TB] FAIL rr_first got=%0d want=1", ids[0]); end
        total++; if (ids[1] !== 2'd3) begin bad++; $display("[TB] FAIL rr_second got=%0d want=3", ids[1]); end
        total++; if (ids[2] !== 2'd0) begin bad++; $display("[TB] FAIL rr_third got=%0d want=0", ids[2]); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        in = 4'b0010;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 7) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid_c%0d got=%b want=1", c, out_valid); end
                total++; if (out_id !== 2'd1) begin bad++; $display("[TB] FAIL bp_id_c%0d got=%0d want=1", c, out_id); end
            end
            if (c == 3) in = 4'b0011;
            if (c == 4) begin
                total++; if (pending !== 4'b0011) begin bad++; $display("[TB] FAIL bp_pending got=%b want=0011", pending); end
            end
            if (c == 7) out_ready = 1'b1;
            if (c == 8) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_after_xfer_valid got=%b want=0", out_valid); end
                total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL bp_after_xfer_pending got=%b want=0001", pending); end
            end
            if (c == 11) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_valid got=%b want=1", out_valid); end
                total++; if (out_id !== 2'd0) begin bad++; $display("[TB] FAIL bp_next_id got=%0d want=0", out_id); end
            end
        end
        in = 4'b0000;
    endtask

    task automatic test_overrun();
        int n;
        n = 0;
        do_reset(1'b0);
        in = 4'b0001;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 5 && out_valid === 1'b1) n++;
            if (c == 2) begin
                total++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin bad++; $display("[TB] FAIL ovr_present got=%b/%0d want=1/0", out_valid, out_id); end
                in = 4'b0000;
            end
            if (c == 3) in = 4'b0001;
            if (c == 4) begin
                total++; if (overrun !== 4'b0001) begin bad++; $display("[TB] FAIL ovr_flag got=%b want=0001", overrun); end
                total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL ovr_pending got=%b want=0001", pending); end
                out_ready = 1'b1;
            end
            if (c == 5) begin
                total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL ovr_merged got=%b want=0000", pending); end
            end
        end
        total++; if (n !== 0) begin bad++; $display("[TB] FAIL ovr_extra_events got=%0d want=0", n); end
        total++; if (overrun !== 4'b0001) begin bad++; $display("[TB] FAIL ovr_sticky got=%b want=0001", overrun); end

        do_reset(1'b1);
        in = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) in = 4'b0000;
            if (c == 2) begin
                total++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin bad++; $display("[TB] FAIL same_present got=%b/%0d want=1/0", out_valid, out_id); end
                in = 4'b0001;
            end
            if (c == 3) begin
                total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL same_pending_kept got=%b want=0001", pending); end
                total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL same_overrun got=%b want=0000", overrun); end
            end
            if (c == 6) begin
                total++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin bad++; $display("[TB] FAIL same_second_event got=%b/%0d want=1/0", out_valid, out_id); end
            end
            if (c == 7) begin
                total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL same_drained got=%b want=0000", pending); end
            end
        end
        in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        do_reset(1'b0);
        in = 4'b0110;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                total++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin bad++; $display("[TB] FAIL mid_present got=%b/%0d want=1/1", out_valid, out_id); end
                total++; if (pending !== 4'b0110) begin bad++; $display("[TB] FAIL mid_pending got=%b want=0110", pending); end
                in = 4'b0010;
            end
            if (c == 3) in = 4'b0110;
            if (c == 4) begin
                total++; if (overrun !== 4'b0100) begin bad++; $display("[TB] FAIL mid_overrun_pre got=%b want=0100", overrun); end
            end
        end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_valid got=%b want=0", out_valid); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL mid_async_pending got=%b want=0000", pending); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL mid_async_overrun got=%b want=0000", overrun); end
        in = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
            if (c == 1) begin
                total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL mid_release_pending got=%b want=0100", pending); end
            end
            if (c == 2) begin
                total++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin bad++; $display("[TB] FAIL mid_release_event got=%b/%0d want=1/2", out_valid, out_id); end
            end
        end
        total++; if (n !== 1) begin bad++; $display("[TB] FAIL mid_release_count got=%0d want=1", n); end
        in = 4'b0000;
    endtask

    // Runs every scenario in order, then reports the tally.
    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
